motor_cmd_rx: RTL and testbench



---
 rtl/motor_cmd_rx.sv | 184 ++++++++++++++++++
 tb/tb_motor_cmd_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_rx.sv
// Frame parser and motion sequencer between the UART receiver and the H-bridge driver.
// Accepts A5/cmd/chk frames, enforces dead time between motion codes and a command watchdog.
module motor_cmd_rx #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned DEAD_CYCLES    = 500_000,
  parameter int unsigned GAP_CYCLES     = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] motor_setting,
  output logic       cmd_ack,
  output logic       frame_err,
  output logic       wdog_trip
);

  // state     | meaning
  // S_IDLE    | hunting for HEADER, other bytes dropped
  // S_GET_CMD | header seen, next byte is the command code
  // S_GET_CHK | command latched, next byte is the checksum
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GET_CMD = 2'd1;
  localparam logic [1:0] S_GET_CHK = 2'd2;

  localparam logic [7:0] CODE_STOP = 8'd5;

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DT_W = $clog2(DEAD_CYCLES + 1);
  localparam int GP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [DT_W-1:0] DT_LOAD  = DT_W'(DEAD_CYCLES);
  localparam logic [DT_W-1:0] DT_ONE   = DT_W'(1);
  localparam logic [GP_W-1:0] GP_LOAD  = GP_W'(GAP_CYCLES);
  localparam logic [GP_W-1:0] GP_ONE   = GP_W'(1);

  logic [1:0]      state, state_nxt;
  logic [7:0]      cmd_q, cmd_nxt;
  logic [GP_W-1:0] gap_cnt, gap_nxt;
  logic            accept, bad_frame, gap_abort;
  logic            chk_ok, code_ok;

  logic [7:0]      motor_nxt;
  logic [7:0]      pend_q, pend_nxt;
  logic            pend_valid, pend_valid_nxt;
  logic [DT_W-1:0] dead_cnt, dead_nxt;
  logic [WD_W-1:0] wd_cnt, wd_nxt;
  logic            trip;
  logic            dead_done;

  assign chk_ok  = (rx_data == ~cmd_q);
  assign code_ok = (cmd_q >= 8'd1) && (cmd_q <= CODE_STOP);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    gap_nxt   = gap_cnt;
    accept    = 1'b0;
    bad_frame = 1'b0;
    gap_abort = 1'b0;
    case (state)
      S_IDLE: begin
        gap_nxt = '0;
        if (rx_valid && (rx_data == HEADER)) begin
          state_nxt = S_GET_CMD;
          gap_nxt   = GP_LOAD;
        end
      end
      S_GET_CMD, S_GET_CHK: begin
        if (rx_valid) begin
          if (state == S_GET_CMD) begin
            cmd_nxt   = rx_data;
            state_nxt = S_GET_CHK;
            gap_nxt   = GP_LOAD;
          end else begin
            state_nxt = S_IDLE;
            gap_nxt   = '0;
            if (chk_ok && code_ok) accept = 1'b1;
            else                   bad_frame = 1'b1;
          end
        end else if (gap_cnt <= GP_ONE) begin
          // A byte arriving on the expiry cycle takes the branch above instead.
          gap_abort = 1'b1;
          state_nxt = S_IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt - GP_ONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        gap_nxt   = '0;
      end
    endcase
  end

  assign dead_done = pend_valid && (dead_cnt <= DT_ONE);

  always_comb begin
    motor_nxt      = motor_setting;
    pend_nxt       = pend_q;
    pend_valid_nxt = pend_valid;
    dead_nxt       = dead_cnt;
    wd_nxt         = wd_cnt;
    trip           = 1'b0;

    if (pend_valid) begin
      if (dead_done) begin
        motor_nxt      = pend_q;
        pend_valid_nxt = 1'b0;
        dead_nxt       = '0;
      end else begin
        dead_nxt = dead_cnt - DT_ONE;
      end
    end

    if (accept) begin
      wd_nxt = '0;
      if (pend_valid) begin
        // Output is already stop; only the pending target changes.
        if (cmd_q == CODE_STOP) begin
          motor_nxt      = CODE_STOP;
          pend_nxt       = CODE_STOP;
          pend_valid_nxt = 1'b0;
          dead_nxt       = '0;
        end else begin
          pend_nxt = cmd_q;
          if (dead_done) motor_nxt = cmd_q;
        end
      end else if (cmd_q != motor_setting) begin
        if ((cmd_q == CODE_STOP) || (motor_setting == CODE_STOP)) begin
          motor_nxt = cmd_q;
        end else begin
          motor_nxt      = CODE_STOP;
          pend_nxt       = cmd_q;
          pend_valid_nxt = 1'b1;
          dead_nxt       = DT_LOAD;
        end
      end
    end else if (wd_cnt == WD_LAST) begin
      trip           = 1'b1;
      wd_nxt         = WD_LIMIT;
      motor_nxt      = CODE_STOP;
      pend_nxt       = CODE_STOP;
      pend_valid_nxt = 1'b0;
      dead_nxt       = '0;
    end else if (wd_cnt != WD_LIMIT) begin
      wd_nxt = wd_cnt + WD_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      cmd_q         <= 8'd0;
      gap_cnt       <= '0;
      motor_setting <= CODE_STOP;
      pend_q        <= CODE_STOP;
      pend_valid    <= 1'b0;
      dead_cnt      <= '0;
      wd_cnt        <= '0;
      cmd_ack       <= 1'b0;
      frame_err     <= 1'b0;
      wdog_trip     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cmd_q         <= cmd_nxt;
      gap_cnt       <= gap_nxt;
      motor_setting <= motor_nxt;
      pend_q        <= pend_nxt;
      pend_valid    <= pend_valid_nxt;
      dead_cnt      <= dead_nxt;
      wd_cnt        <= wd_nxt;
      cmd_ack       <= accept;
      frame_err     <= bad_frame | gap_abort;
      wdog_trip     <= trip;
    end
  end

endmodule

// File: tb/tb_motor_cmd_rx.sv
// Directed bench for motor_cmd_rx with shortened timers (timeout 1000, dead 16, gap 200).
module tb_motor_cmd_rx;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] motor_setting;
  logic       cmd_ack;
  logic       frame_err;
  logic       wdog_trip;

  int n_chk;
  int n_err;
  int n_trip;
  int n;
  int snap;

  motor_cmd_rx #(
    .HEADER        (8'hA5),
    .TIMEOUT_CYCLES(1000),
    .DEAD_CYCLES   (16),
    .GAP_CYCLES    (200)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .motor_setting(motor_setting),
    .cmd_ack      (cmd_ack),
    .frame_err    (frame_err),
    .wdog_trip    (wdog_trip)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (wdog_trip) n_trip++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is sampled on the next rising edge and the
  // task returns on the falling edge right after it.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    n_chk = 0; n_err = 0; n_trip = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_motor", motor_setting, 5);
    check("rst_ack", cmd_ack, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_trip", wdog_trip, 0);
    rst = 1'b0;
    @(negedge clk);

    send_frame(8'h01, 8'hFE);
    check("fwd_ack", cmd_ack, 1);
    check("fwd_motor", motor_setting, 1);
    @(negedge clk);
    check("fwd_ack_pulse", cmd_ack, 0);
    check("fwd_motor_hold", motor_setting, 1);

    // 1 -> 2 with a replacement to 4 inside the dead window
    send_frame(8'h02, 8'hFD);
    check("dead_ack", cmd_ack, 1);
    check("dead_motor_stop", motor_setting, 5);
    send_frame(8'h04, 8'hFB);
    check("dead_repl_ack", cmd_ack, 1);
    check("dead_repl_motor", motor_setting, 5);
    repeat (12) @(negedge clk);
    check("dead_cyc16", motor_setting, 5);
    @(negedge clk);
    check("dead_cyc17", motor_setting, 4);

    // 4 -> 2: stop must last exactly 16 cycles
    send_frame(8'h02, 8'hFD);
    n = 0;
    while (motor_setting == 8'd5 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("dead_len", n, 16);
    check("dead_final", motor_setting, 2);

    send_frame(8'h03, 8'h00);
    check("badchk_ferr", frame_err, 1);
    check("badchk_ack", cmd_ack, 0);
    check("badchk_motor", motor_setting, 2);
    send_frame(8'h07, 8'hF8);
    check("badcode_ferr", frame_err, 1);
    check("badcode_motor", motor_setting, 2);
    @(negedge clk);
    check("ferr_pulse", frame_err, 0);

    // gap abort after header + cmd
    send_byte(8'hA5);
    send_byte(8'h01);
    n = 1;
    while (!frame_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("gap_cycles", n, 201);
    send_byte(8'h01);
    send_byte(8'hFE);
    check("gap_ignored_ack", cmd_ack, 0);
    check("gap_ignored_motor", motor_setting, 2);
    send_frame(8'h05, 8'hFA);
    check("stop_ack", cmd_ack, 1);
    check("stop_motor", motor_setting, 5);
    send_frame(8'h03, 8'hFC);
    check("right_motor", motor_setting, 3);

    // watchdog from 3
    snap = n_trip;
    n = 1;
    while (!wdog_trip && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("wdog_cycles", n, 1001);
    check("wdog_motor", motor_setting, 5);
    repeat (2000) @(negedge clk);
    check("wdog_single_trip", n_trip - snap, 1);

    // stop cancels a pending move
    send_frame(8'h01, 8'hFE);
    check("cancel_pre", motor_setting, 1);
    send_frame(8'h02, 8'hFD);
    send_frame(8'h05, 8'hFA);
    check("cancel_ack", cmd_ack, 1);
    repeat (20) @(negedge clk);
    check("cancel_motor", motor_setting, 5);

    // reset while pending=2
    send_frame(8'h01, 8'hFE);
    send_frame(8'h02, 8'hFD);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dead_motor", motor_setting, 5);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (motor_setting != 8'd5) n++;
    end
    check("rst_dead_no_resume", n, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
